// File: rtl/ram_com_client.sv
// ============================================================================
// Module   : ram_com_client
// Function : com-link byte command initiator for the shared scratch RAM
//            (lowest-priority port), with lost-arbitration retry.
//            Optional macro RAM_COM_WR_ACK_EN: writes return a response.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_com_client #(
  parameter int ADDR_W    = 32,
  parameter int MAX_RETRY = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_err,
  output logic [31:0]       o_com_addr,
  output logic [7:0]        o_com_wdata,
  output logic [3:0]        o_wen_com,
  output logic              o_com_valid,
  output logic              o_com_rvalid,
  input  logic [31:0]       i_mem_rdata,
  input  logic [2:0]        i_ram_valid,
  input  logic              i_hp_wr_busy
);

  localparam logic [3:0] c_max_retry = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_REQ     = 3'd1,
    WR_GAP     = 3'd2,
    WR_BACKOFF = 3'd3,
    RD_REQ     = 3'd4,
    RD_WAIT    = 3'd5,
    RSP        = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  lane_q, lane_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [3:0]  rc_q, rc_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        com_valid_q, com_valid_d;
  logic        com_rvalid_q, com_rvalid_d;
  logic [31:0] com_addr_q, com_addr_d;
  logic [7:0]  com_wdata_q, com_wdata_d;
  logic [3:0]  wen_com_q, wen_com_d;

  // Only the com grant bit matters to this requester.
  logic unused_ram_valid;
  assign unused_ram_valid = &{1'b0, i_ram_valid[2:1]};

  assign cmd_ready = (state_q == IDLE) && !rst;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    rc_d        = rc_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          word_d  = 32'(cmd_addr[ADDR_W-1:2]);
          lane_d  = cmd_addr[1:0];
          wdata_d = cmd_wdata;
          rc_d    = 4'd0;
          state_d = cmd_write ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        if (i_hp_wr_busy) begin
          rc_d    = rc_q + 4'd1;
          state_d = WR_BACKOFF;
        end else begin
          state_d = WR_GAP;
        end
      end
      WR_GAP: begin
        // A high-priority write here overwrote our staged write before commit.
        if (i_hp_wr_busy) begin
          rc_d    = rc_q + 4'd1;
          state_d = WR_BACKOFF;
        end else begin
`ifdef RAM_COM_WR_ACK_EN
          rsp_rdata_d = 8'd0;
          rsp_err_d   = 1'b0;
          state_d     = RSP;
`else
          state_d     = IDLE;
`endif
        end
      end
      WR_BACKOFF: begin
        if (rc_q == c_max_retry) begin
`ifdef RAM_COM_WR_ACK_EN
          rsp_rdata_d = 8'd0;
          rsp_err_d   = 1'b1;
          state_d     = RSP;
`else
          state_d     = IDLE;
`endif
        end else begin
          state_d = WR_REQ;
        end
      end
      RD_REQ: state_d = RD_WAIT;
      RD_WAIT: begin
        if (i_ram_valid[0]) begin
          rsp_rdata_d = i_mem_rdata[{lane_q, 3'b000} +: 8];
          rsp_err_d   = 1'b0;
          state_d     = RSP;
        end else begin
          rc_d = rc_q + 4'd1;
          if (rc_d == c_max_retry) begin
            rsp_rdata_d = 8'd0;
            rsp_err_d   = 1'b1;
            state_d     = RSP;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_rdata_d = 8'd0;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Request outputs are registered from the next state, so they line up
    // exactly with the cycle the FSM sits in the request state.
    com_valid_d  = (state_d == WR_REQ);
    com_rvalid_d = (state_d == RD_REQ);
    com_addr_d   = (com_valid_d || com_rvalid_d) ? word_d : 32'd0;
    com_wdata_d  = com_valid_d ? wdata_d : 8'd0;
    wen_com_d    = com_valid_d ? (4'b0001 << lane_d) : 4'd0;
    rsp_valid_d  = (state_d == RSP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      word_q       <= '0;
      lane_q       <= '0;
      wdata_q      <= '0;
      rc_q         <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      com_valid_q  <= 1'b0;
      com_rvalid_q <= 1'b0;
      com_addr_q   <= '0;
      com_wdata_q  <= '0;
      wen_com_q    <= '0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      rc_q         <= rc_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      rsp_valid_q  <= rsp_valid_d;
      com_valid_q  <= com_valid_d;
      com_rvalid_q <= com_rvalid_d;
      com_addr_q   <= com_addr_d;
      com_wdata_q  <= com_wdata_d;
      wen_com_q    <= wen_com_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign o_com_valid  = com_valid_q;
  assign o_com_rvalid = com_rvalid_q;
  assign o_com_addr   = com_addr_q;
  assign o_com_wdata  = com_wdata_q;
  assign o_wen_com    = wen_com_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_com_client.sv
// ============================================================================
// Module   : tb_ram_com_client
// Function : randomized self-checking bench for ram_com_client
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ram_com_client;

  localparam int MAX_RETRY = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [7:0]  rsp_rdata;
  logic [31:0] o_com_addr;
  logic [7:0]  o_com_wdata;
  logic [3:0]  o_wen_com;
  logic        o_com_valid, o_com_rvalid;
  logic [31:0] i_mem_rdata;
  logic [2:0]  i_ram_valid;
  logic        i_hp_wr_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_com_client #(.ADDR_W(32), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .o_com_addr(o_com_addr), .o_com_wdata(o_com_wdata), .o_wen_com(o_wen_com),
    .o_com_valid(o_com_valid), .o_com_rvalid(o_com_rvalid),
    .i_mem_rdata(i_mem_rdata), .i_ram_valid(i_ram_valid), .i_hp_wr_busy(i_hp_wr_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write command; the first nlost attempts lose arbitration, each either in
  // the request cycle or in the commit gap (chosen at random).
  task automatic do_write(input logic [31:0] addr, input logic [7:0] data, input int nlost);
    int  kind[16];
    int  exp_pulses, exp_done, pulses, t;
    bit  exp_err, prev_v, done;
    for (int i = 0; i < 16; i++) kind[i] = (i < nlost) ? 1 + $urandom_range(0, 1) : 0;
    exp_err    = (nlost >= MAX_RETRY);
    exp_pulses = exp_err ? MAX_RETRY : nlost + 1;
    exp_done   = 1;
    for (int a = 0; a < exp_pulses; a++) exp_done += (kind[a] == 2) ? 3 : 2;

    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL wr_accept_ready: got %b expected 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_wdata = data;
    step();
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = 8'($urandom);

    pulses = 0; prev_v = 1'b0; done = 1'b0; t = 1;
    while (!done && t < 200) begin
      checks++;
      if (o_com_rvalid !== 1'b0) begin
        errors++; $display("FAIL wr_no_rvalid: got %b expected 0 (cycle %0d)", o_com_rvalid, t);
      end
      if (o_com_valid === 1'b1) begin
        pulses++;
        checks++;
        if ({o_com_addr, o_com_wdata, o_wen_com} !== {addr >> 2, data, 4'b0001 << addr[1:0]}) begin
          errors++;
          $display("FAIL wr_request: got addr=%h data=%h wen=%b expected addr=%h data=%h wen=%b",
                   o_com_addr, o_com_wdata, o_wen_com, addr >> 2, data, 4'b0001 << addr[1:0]);
        end
        i_hp_wr_busy = (pulses <= 16) && (kind[pulses-1] == 1);
        prev_v = 1'b1;
      end else begin
        checks++;
        if (o_wen_com !== 4'd0) begin
          errors++; $display("FAIL wr_wen_idle: got %b expected 0000", o_wen_com);
        end
        if (prev_v) i_hp_wr_busy = (pulses >= 1) && (pulses <= 16) && (kind[pulses-1] == 2);
        else        i_hp_wr_busy = 1'($urandom);
        prev_v = 1'b0;
      end
      done = (cmd_ready === 1'b1) || (rsp_valid === 1'b1);
      if (!done) begin
        step();
        t++;
      end
    end
    i_hp_wr_busy = 1'b0;

    checks++;
    if (!done) begin
      errors++; $display("FAIL wr_timeout: no completion after %0d cycles", t);
    end
    checks++;
    if (t != exp_done) begin
      errors++; $display("FAIL wr_latency: got %0d cycles expected %0d", t, exp_done);
    end
    checks++;
    if (pulses != exp_pulses) begin
      errors++; $display("FAIL wr_pulses: got %0d expected %0d", pulses, exp_pulses);
    end
`ifdef RAM_COM_WR_ACK_EN
    checks++;
    if ({rsp_valid, cmd_ready, rsp_err, rsp_rdata} !== {1'b1, 1'b0, exp_err, 8'd0}) begin
      errors++;
      $display("FAIL wr_ack: got valid=%b ready=%b err=%b rdata=%h expected valid=1 ready=0 err=%b rdata=00",
               rsp_valid, cmd_ready, rsp_err, rsp_rdata, exp_err);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL wr_ack_release: got valid=%b ready=%b expected valid=0 ready=1", rsp_valid, cmd_ready);
    end
`else
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL wr_posted: got rsp_valid=%b expected 0", rsp_valid);
    end
`endif
  endtask

  // Read command; the first nlost RAM grant checks go to other requesters,
  // then the response is held off for holdoff cycles.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] word, input int nlost, input int holdoff);
    int         exp_pulses, exp_done, pulses, t;
    bit         exp_err, prev_v, done;
    logic [7:0] exp_byte, held_rdata;
    logic       held_err;
    exp_err    = (nlost >= MAX_RETRY);
    exp_pulses = exp_err ? MAX_RETRY : nlost + 1;
    exp_done   = 1 + 2 * exp_pulses;
    exp_byte   = exp_err ? 8'd0 : 8'(word >> (8 * addr[1:0]));

    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rd_accept_ready: got %b expected 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_wdata = 8'($urandom);
    step();
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom;

    pulses = 0; prev_v = 1'b0; done = 1'b0; t = 1;
    while (!done && t < 200) begin
      checks++;
      if (o_com_valid !== 1'b0) begin
        errors++; $display("FAIL rd_no_write: got o_com_valid=%b expected 0 (cycle %0d)", o_com_valid, t);
      end
      if (o_com_rvalid === 1'b1) begin
        pulses++;
        checks++;
        if ({o_com_addr, o_wen_com} !== {addr >> 2, 4'd0}) begin
          errors++;
          $display("FAIL rd_request: got addr=%h wen=%b expected addr=%h wen=0000", o_com_addr, o_wen_com, addr >> 2);
        end
        i_ram_valid = 3'($urandom); i_mem_rdata = $urandom;
        prev_v = 1'b1;
      end else begin
        if (prev_v) begin
          i_ram_valid = (pulses - 1 >= nlost) ? 3'b001 : 3'(2 * $urandom_range(0, 2));
          i_mem_rdata = word;
        end else begin
          i_ram_valid = 3'($urandom); i_mem_rdata = $urandom;
        end
        prev_v = 1'b0;
      end
      done = (cmd_ready === 1'b1) || (rsp_valid === 1'b1);
      if (!done) begin
        step();
        t++;
      end
    end

    checks++;
    if (!done) begin
      errors++; $display("FAIL rd_timeout: no response after %0d cycles", t);
    end
    checks++;
    if (t != exp_done) begin
      errors++; $display("FAIL rd_latency: got %0d cycles expected %0d", t, exp_done);
    end
    checks++;
    if (pulses != exp_pulses) begin
      errors++; $display("FAIL rd_pulses: got %0d expected %0d", pulses, exp_pulses);
    end
    checks++;
    if ({rsp_valid, cmd_ready, rsp_err, rsp_rdata} !== {1'b1, 1'b0, exp_err, exp_byte}) begin
      errors++;
      $display("FAIL rd_response: got valid=%b ready=%b err=%b rdata=%h expected valid=1 ready=0 err=%b rdata=%h",
               rsp_valid, cmd_ready, rsp_err, rsp_rdata, exp_err, exp_byte);
    end
    held_rdata = rsp_rdata;
    held_err   = rsp_err;

    for (int h = 0; h < holdoff; h++) begin
      rsp_ready = 1'b0;
      cmd_valid = 1'($urandom); cmd_write = 1'($urandom); cmd_addr = $urandom;
      i_ram_valid = 3'($urandom); i_mem_rdata = $urandom; i_hp_wr_busy = 1'($urandom);
      step();
      checks++;
      if ({rsp_valid, cmd_ready, rsp_err, rsp_rdata} !== {1'b1, 1'b0, held_err, held_rdata}) begin
        errors++;
        $display("FAIL rd_backpressure: got valid=%b ready=%b err=%b rdata=%h expected valid=1 ready=0 err=%b rdata=%h",
                 rsp_valid, cmd_ready, rsp_err, rsp_rdata, held_err, held_rdata);
      end
    end
    cmd_valid = 1'b0;
    i_hp_wr_busy = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL rd_release: got valid=%b ready=%b expected valid=0 ready=1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; i_mem_rdata = '0; i_ram_valid = '0; i_hp_wr_busy = 1'b0;
    step();
    step();
    checks++;
    if ({cmd_ready, o_com_valid, o_com_rvalid, o_com_addr, o_com_wdata, o_wen_com,
         rsp_valid, rsp_rdata, rsp_err} !== 57'd0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs (cmd_ready=%b rsp_valid=%b) expected all 0",
                         cmd_ready, rsp_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_reset_mid_read();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_accept: got %b expected 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0006;
    step();
    cmd_valid = 1'b0;
    checks++;
    if (o_com_rvalid !== 1'b1) begin
      errors++; $display("FAIL rst_mid_rvalid: got %b expected 1", o_com_rvalid);
    end
    step();
    rst = 1'b1; i_ram_valid = 3'b001; i_mem_rdata = 32'hDEAD_BEEF;
    step();
    checks++;
    if ({cmd_ready, o_com_valid, o_com_rvalid, o_com_addr, o_com_wdata, o_wen_com,
         rsp_valid, rsp_rdata, rsp_err} !== 57'd0) begin
      errors++; $display("FAIL rst_mid_outputs: got rsp_valid=%b rdata=%h addr=%h expected all 0",
                         rsp_valid, rsp_rdata, o_com_addr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_ready: got %b expected 1", cmd_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({rsp_valid, o_com_rvalid, cmd_ready} !== 3'b001) begin
        errors++; $display("FAIL rst_mid_quiet: got valid=%b rvalid=%b ready=%b expected 0 0 1",
                           rsp_valid, o_com_rvalid, cmd_ready);
      end
    end
  endtask

  task automatic test_write_basic();
    do_write(32'h0000_0009, 8'hA5, 0);
  endtask

  task automatic test_read_basic();
    do_read(32'h0000_000B, 32'h1122_3344, 0, 0);
  endtask

  task automatic test_read_retry();
    do_read(32'h0000_0102, 32'hCAFE_F00D, 2, 0);
  endtask

  task automatic test_write_exhaust();
    do_write(32'h0000_0040, 8'h3C, 20);
    do_write(32'h0000_0041, 8'hC3, MAX_RETRY - 1);
  endtask

  task automatic test_read_exhaust();
    do_read(32'h0000_0203, 32'h5566_7788, MAX_RETRY, 2);
    do_read(32'h0000_0201, 32'h5566_7788, MAX_RETRY - 1, 0);
  endtask

  task automatic test_backpressure();
    do_read(32'h0000_0010, 32'h0BAD_F00D, 0, 10);
  endtask

  task automatic test_back_to_back_random();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_write($urandom, 8'($urandom), $urandom_range(0, 9));
      else
        do_read($urandom, $urandom, $urandom_range(0, 9), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_read_retry();
    test_write_exhaust();
    test_read_exhaust();
    test_backpressure();
    test_reset_mid_read();
    test_back_to_back_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
